iir_deemph: RTL and testbench

IIR_DEEMPH -- requirements
Module: iir_deemph

---
 rtl/iir_pkg.sv | 19 +
 rtl/deq_mult.sv | 21 ++
 rtl/iir_deemph.sv | 124 ++++++++++++
 tb/tb_iir_deemph.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types and fixed-point helpers for the de-emphasis IIR.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam int QUANT_BITS = 10;

    // Arithmetic shift floors, so negative products get a bias first to round toward zero.
    function automatic logic signed [63:0] deq(input logic signed [63:0] p);
        logic signed [63:0] bias;
        bias = p[63] ? ((64'sd1 <<< QUANT_BITS) - 64'sd1) : '0;
        return (p + bias) >>> QUANT_BITS;
    endfunction

endpackage

// File: rtl/deq_mult.sv
// Signed coefficient x sample multiply followed by Q10 dequantize (toward zero).
module deq_mult
    import iir_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           coef,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [63:0]           term
);

    logic signed [63:0] coef_ext;
    logic signed [63:0] sample_ext;
    logic signed [63:0] product;

    assign coef_ext   = 64'(signed'(coef));
    assign sample_ext = 64'(signed'(sample));
    assign product    = coef_ext * sample_ext;
    assign term       = deq(product);

endmodule

// File: rtl/iir_deemph.sv
// First-order de-emphasis IIR, one shared multiplier, three MAC cycles per sample.
// Define IIR_DEEMPH_SATURATE_EN to clamp the output instead of wrapping it.
module iir_deemph
    import iir_pkg::*;
#(
    parameter int                 DATA_WIDTH = 32,
    parameter logic signed [31:0] X0         = 32'sd178,
    parameter logic signed [31:0] X1         = 32'sd178,
    parameter logic signed [31:0] Y1         = 32'sd663
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              mac_cnt;
    logic signed [63:0]      acc;
    logic [DATA_WIDTH-1:0]   x_cur;
    logic [DATA_WIDTH-1:0]   x_prev;
    logic [DATA_WIDTH-1:0]   y_prev;
    logic [31:0]             coef;
    logic [DATA_WIDTH-1:0]   operand;
    logic [63:0]             term;
    logic [DATA_WIDTH-1:0]   result;

    always_comb begin
        coef    = Y1;
        operand = y_prev;
        case (mac_cnt)
            2'd0: begin
                coef    = X0;
                operand = x_cur;
            end
            2'd1: begin
                coef    = X1;
                operand = x_prev;
            end
            default: ;
        endcase
    end

    deq_mult #(.DATA_WIDTH(DATA_WIDTH)) u_deq_mult (
        .coef   (coef),
        .sample (operand),
        .term   (term)
    );

`ifdef IIR_DEEMPH_SATURATE_EN
    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DATA_WIDTH - 1));

    logic signed [63:0] sum;

    assign sum = acc + signed'(term);

    always_comb begin
        if (sum > SAT_MAX) begin
            result = DATA_WIDTH'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            result = DATA_WIDTH'(SAT_MIN);
        end else begin
            result = DATA_WIDTH'(sum);
        end
    end
`else
    assign result = DATA_WIDTH'(acc + signed'(term));
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MAC;
            MAC:     if (mac_cnt == 2'd2) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mac_cnt  <= '0;
            acc      <= '0;
            x_cur    <= '0;
            x_prev   <= '0;
            y_prev   <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_cur   <= in_data;
                        acc     <= '0;
                        mac_cnt <= '0;
                    end
                end
                MAC: begin
                    if (mac_cnt == 2'd2) begin
                        // Feedback uses the value actually emitted, after clamp or wrap.
                        out_data <= result;
                        x_prev   <= x_cur;
                        y_prev   <= result;
                    end else begin
                        acc     <= acc + signed'(term);
                        mac_cnt <= mac_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_deemph.sv
// Scoreboard bench for iir_deemph: five instances with different coefficients, lockstep stimulus.
module tb_iir_deemph;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        ir [5];
    logic        ov [5];
    logic [31:0] od [5];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    longint      mxp;
    longint      myp;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    always #5 clock = ~clock;

    iir_deemph #(.DATA_WIDTH(32), .X0(32'sd178), .X1(32'sd178), .Y1(32'sd663)) u0 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready));
    iir_deemph #(.DATA_WIDTH(32), .X0(32'sd512), .X1(32'sd512), .Y1(32'sd0)) u1 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready));
    iir_deemph #(.DATA_WIDTH(32), .X0(32'sd1024), .X1(32'sd0), .Y1(32'sd512)) u2 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready));
    iir_deemph #(.DATA_WIDTH(32), .X0(32'sd512), .X1(32'sd0), .Y1(32'sd0)) u3 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[3]),
        .out_data(od[3]), .out_valid(ov[3]), .out_ready(out_ready));
    iir_deemph #(.DATA_WIDTH(32), .X0(32'sd1048576), .X1(32'sd0), .Y1(32'sd0)) u4 (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[4]),
        .out_data(od[4]), .out_valid(ov[4]), .out_ready(out_ready));

    function automatic logic [31:0] fit(input longint s);
`ifdef IIR_DEEMPH_SATURATE_EN
        if (s > MAXV) return 32'h7FFF_FFFF;
        if (s < MINV) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // Reference uses SV integer division, which truncates toward zero.
    function automatic logic [31:0] model(input longint a0, input longint a1, input longint b1,
                                          input logic [31:0] x);
        longint      xs;
        longint      s;
        logic [31:0] r;
        xs  = longint'($signed(x));
        s   = (a0 * xs) / 1024 + (a1 * mxp) / 1024 + (b1 * myp) / 1024;
        r   = fit(s);
        mxp = xs;
        myp = longint'($signed(r));
        return r;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        mxp       = 0;
        myp       = 0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic send(input logic [31:0] x, output bit ok);
        int n = 0;
        while (!ir[0] && n < 20) begin
            @(negedge clock);
            n++;
        end
        ok       = ir[0];
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(input int k, output logic [31:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (ov[k]) begin
                d  = od[k];
                ok = 1'b1;
                break;
            end
        end
        if (ok && out_ready) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (ov[k] !== 1'b0 || od[k] !== 32'd0) begin
                bad++;
                $display("FAIL reset_out[%0d] got valid=%b data=%h exp valid=0 data=0", k, ov[k], od[k]);
            end
        end
        #1 reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d] got ready=%b valid=%b exp ready=1 valid=0", k, ir[k], ov[k]);
            end
        end
    endtask

    task automatic test_feedforward();
        logic [31:0] xs [3] = '{32'd1024, 32'd0, 32'd0};
        logic [31:0] ev [3] = '{32'd512, 32'd512, 32'd0};
        logic [31:0] d, e;
        bit sok, rok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xs[i], sok);
            exp_q.push_back(ev[i]);
            recv(1, d, rok);
            e = exp_q.pop_front();
            total++;
            if (!sok || !rok || d !== e) begin
                bad++;
                $display("FAIL feedforward[%0d] got=%0d exp=%0d ok=%b%b", i, $signed(d), $signed(e), sok, rok);
            end
        end
    endtask

    task automatic test_feedback();
        logic [31:0] xs [3] = '{32'd1024, 32'd0, 32'd0};
        logic [31:0] ev [3] = '{32'd1024, 32'd512, 32'd256};
        logic [31:0] d, e;
        bit sok, rok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xs[i], sok);
            exp_q.push_back(ev[i]);
            recv(2, d, rok);
            e = exp_q.pop_front();
            total++;
            if (!sok || !rok || d !== e) begin
                bad++;
                $display("FAIL feedback[%0d] got=%0d exp=%0d ok=%b%b", i, $signed(d), $signed(e), sok, rok);
            end
        end
    endtask

    task automatic test_round_toward_zero();
        logic [31:0] xs [4] = '{-32'sd3, 32'sd3, -32'sd1025, 32'sd1025};
        logic [31:0] ev [4] = '{-32'sd1, 32'sd1, -32'sd512, 32'sd512};
        logic [31:0] d, e;
        bit sok, rok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(xs[i], sok);
            exp_q.push_back(ev[i]);
            recv(3, d, rok);
            e = exp_q.pop_front();
            total++;
            if (!sok || !rok || d !== e) begin
                bad++;
                $display("FAIL round[%0d] got=%0d exp=%0d ok=%b%b", i, $signed(d), $signed(e), sok, rok);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] xs [2] = '{32'h0100_0000, 32'hFF00_0000};
        logic [31:0] d, e;
        bit sok, rok;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            send(xs[i], sok);
            exp_q.push_back(model(1048576, 0, 0, xs[i]));
            recv(4, d, rok);
            e = exp_q.pop_front();
            total++;
            if (!sok || !rok || d !== e) begin
                bad++;
                $display("FAIL overflow[%0d] got=%h exp=%h ok=%b%b", i, d, e, sok, rok);
            end
        end
    endtask

    task automatic test_default_coeffs();
        logic [31:0] xs [8] = '{32'sd1000, -32'sd2000, 32'sd32767, -32'sd32768,
                                32'sd123456, 32'sd0, 32'sd5, -32'sd7};
        logic [31:0] d, e;
        bit sok, rok;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(xs[i], sok);
            exp_q.push_back(model(178, 178, 663, xs[i]));
            recv(0, d, rok);
            e = exp_q.pop_front();
            total++;
            if (!sok || !rok || d !== e) begin
                bad++;
                $display("FAIL default[%0d] got=%0d exp=%0d ok=%b%b", i, $signed(d), $signed(e), sok, rok);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0, e;
        bit sok, rok;
        do_reset();
        out_ready = 1'b0;
        send(32'sd1000, sok);
        exp_q.push_back(model(178, 178, 663, 32'sd1000));
        recv(0, d0, rok);
        e = exp_q.pop_front();
        total++;
        if (!sok || !rok || d0 !== e) begin
            bad++;
            $display("FAIL bp_data got=%0d exp=%0d ok=%b%b", $signed(d0), $signed(e), sok, rok);
        end
        // A new sample offered while stalled must be ignored.
        in_data  = 32'd999;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (ov[0] !== 1'b1 || od[0] !== d0 || ir[0] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got valid=%b data=%0d ready=%b exp valid=1 data=%0d ready=0",
                         i, ov[0], $signed(od[0]), ir[0], $signed(d0));
            end
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", ov[0], ir[0]);
        end
        @(negedge clock);
        send(32'sd0, sok);
        exp_q.push_back(model(178, 178, 663, 32'sd0));
        recv(0, d0, rok);
        e = exp_q.pop_front();
        total++;
        if (!sok || !rok || d0 !== e) begin
            bad++;
            $display("FAIL bp_next got=%0d exp=%0d ok=%b%b", $signed(d0), $signed(e), sok, rok);
        end
    endtask

    task automatic test_back_to_back();
        int          acc_cyc [$];
        int          val_cyc [$];
        logic [31:0] e;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            in_data  = 32'(100 * c + 7);
            in_valid = 1'b1;
            if (ir[0]) begin
                exp_q.push_back(model(178, 178, 663, in_data));
                acc_cyc.push_back(c);
            end
            if (ov[0]) begin
                val_cyc.push_back(c);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                total++;
                if (od[0] !== e) begin
                    bad++;
                    $display("FAIL b2b_data[%0d] got=%0d exp=%0d", c, $signed(od[0]), $signed(e));
                end
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        total++;
        if (acc_cyc.size() < 2 || val_cyc.size() < 2) begin
            bad++;
            $display("FAIL b2b_count got accepts=%0d outputs=%0d exp >=2 each", acc_cyc.size(), val_cyc.size());
        end else begin
            total++;
            if (val_cyc[0] - acc_cyc[0] != 4) begin
                bad++;
                $display("FAIL b2b_latency got=%0d exp=4", val_cyc[0] - acc_cyc[0]);
            end
            total++;
            if (acc_cyc[1] - acc_cyc[0] != 5) begin
                bad++;
                $display("FAIL b2b_period got=%0d exp=5", acc_cyc[1] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [31:0] d;
        bit sok, rok;
        do_reset();
        send(32'd1024, sok);
        recv(2, d, rok);
        total++;
        if (!sok || !rok || d !== 32'd1024) begin
            bad++;
            $display("FAIL midrst_first got=%0d exp=1024 ok=%b%b", $signed(d), sok, rok);
        end
        send(32'd1024, sok);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clock);
        total++;
        if (ov[2] !== 1'b0 || ir[2] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state got valid=%b ready=%b exp valid=0 ready=1", ov[2], ir[2]);
        end
        send(32'd1024, sok);
        recv(2, d, rok);
        total++;
        if (!sok || !rok || d !== 32'd1024) begin
            bad++;
            $display("FAIL midrst_history got=%0d exp=1024 ok=%b%b", $signed(d), sok, rok);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        mxp       = 0;
        myp       = 0;
        test_reset();
        test_feedforward();
        test_feedback();
        test_round_toward_zero();
        test_overflow();
        test_default_coeffs();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
